// File: rtl/peripheral_mpi_wb_master.sv
`default_nettype none
// ============================================================================
// Module      : peripheral_mpi_wb_master
// Description : Wishbone classic-cycle master for the 8-bit MPI/UART slave
//               register port. Register commands are queued in a small FIFO,
//               each issues one bus cycle with a bounded ack timeout, and one
//               response (read data + error flag) is returned per command.
// Revision    : 1.0 - initial release
// ============================================================================
module peripheral_mpi_wb_master #(
  parameter int FIFO_DEPTH = 4,   // command FIFO entries, power of two, >= 2
  parameter int TIMEOUT    = 255  // max stb cycles waiting for ack, 0 = forever
) (
  input  logic       clk,
  input  logic       rst,         // asynchronous, active-low
  // command stream
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic       cmd_we_i,
  input  logic [2:0] cmd_adr_i,
  input  logic [7:0] cmd_dat_i,
  // response stream
  output logic       rsp_valid_o,
  input  logic       rsp_ready_i,
  output logic [7:0] rsp_dat_o,
  output logic       rsp_err_o,
  // Wishbone master port
  output logic [2:0] wb_adr_o,
  output logic [7:0] wb_dat_o,
  input  logic [7:0] wb_dat_i,
  output logic       wb_we_o,
  output logic [3:0] wb_sel_o,
  output logic       wb_stb_o,
  output logic       wb_cyc_o,
  input  logic       wb_ack_i,
  // status
  output logic       busy_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUS  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  // --------------------------------------------------------------------------
  // Command FIFO: {we, adr[2:0], dat[7:0]}, pointers carry one extra wrap bit
  // --------------------------------------------------------------------------
  logic [11:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic [11:0] fifo_head;

  // FSM and datapath registers
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    adr_q, adr_d;
  logic [7:0]    dat_q, dat_d;
  logic          we_q, we_d;
  logic          cyc_q, cyc_d;
  logic [7:0]    rsp_dat_q, rsp_dat_d;
  logic          rsp_err_q, rsp_err_d;
  logic          timeout_hit;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];

  // Ready is held low while in reset so nothing is accepted into a cleared FIFO
  assign cmd_ready_o = rst & ~fifo_full;
  assign push        = cmd_valid_i & cmd_ready_o;
  // The head is consumed when the FSM launches a new bus cycle
  assign pop         = (state_q == S_IDLE) & ~fifo_empty;

  // Timeout is only armed for a non-zero TIMEOUT
  assign timeout_hit = (TIMEOUT != 0) && (timer_q == TIMER_LAST);

  // Pointer next-state: a pop while full frees the slot only from next cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  // FIFO storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_we_i, cmd_adr_i, cmd_dat_i};
  end

  // FIFO pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Bus FSM
  // --------------------------------------------------------------------------

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state: ack beats timeout, response back-pressure blocks new cycles
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!fifo_empty) state_d = S_BUS;
      S_BUS:  if (wb_ack_i || timeout_hit) state_d = S_RESP;
      S_RESP: if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath next values: launch, hold, and capture of bus results
  always_comb begin
    adr_d     = adr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    timer_d   = timer_q;
    rsp_dat_d = rsp_dat_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          {we_d, adr_d, dat_d} = fifo_head;
          cyc_d   = 1'b1;
          timer_d = '0;
        end
      end
      S_BUS: begin
        // Saturating timer so a long wait never aliases back to zero
        if (timer_q != TIMER_MAX) timer_d = timer_q + TW'(1);
        if (wb_ack_i) begin
          rsp_dat_d = we_q ? 8'h00 : wb_dat_i;
          rsp_err_d = 1'b0;
          cyc_d     = 1'b0;
        end else if (timeout_hit) begin
          rsp_dat_d = 8'h00;
          rsp_err_d = 1'b1;
          cyc_d     = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers driving the bus and response outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      adr_q     <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      timer_q   <= '0;
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      timer_q   <= timer_d;
      rsp_dat_q <= rsp_dat_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_we_o     = we_q;
  assign wb_sel_o    = 4'b0001 << adr_q[1:0];
  assign wb_cyc_o    = cyc_q;
  assign wb_stb_o    = cyc_q;
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;
  assign busy_o      = ~fifo_empty | (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_peripheral_mpi_wb_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_peripheral_mpi_wb_master
// Description : Directed self-checking bench for peripheral_mpi_wb_master.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_mpi_wb_master;

  localparam int FIFO_DEPTH = 4;
  localparam int TIMEOUT    = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       cmd_valid_i = 1'b0;
  logic       cmd_ready_o;
  logic       cmd_we_i = 1'b0;
  logic [2:0] cmd_adr_i = '0;
  logic [7:0] cmd_dat_i = '0;
  logic       rsp_valid_o;
  logic       rsp_ready_i = 1'b0;
  logic [7:0] rsp_dat_o;
  logic       rsp_err_o;
  logic [2:0] wb_adr_o;
  logic [7:0] wb_dat_o;
  logic [7:0] wb_dat_i = '0;
  logic       wb_we_o;
  logic [3:0] wb_sel_o;
  logic       wb_stb_o;
  logic       wb_cyc_o;
  logic       wb_ack_i = 1'b0;
  logic       busy_o;

  peripheral_mpi_wb_master #(
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid_i(cmd_valid_i),
    .cmd_ready_o(cmd_ready_o),
    .cmd_we_i   (cmd_we_i),
    .cmd_adr_i  (cmd_adr_i),
    .cmd_dat_i  (cmd_dat_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o  (rsp_dat_o),
    .rsp_err_o  (rsp_err_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_dat_i   (wb_dat_i),
    .wb_we_o    (wb_we_o),
    .wb_sel_o   (wb_sel_o),
    .wb_stb_o   (wb_stb_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_ack_i   (wb_ack_i),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Single-command vectors; delay = wait cycles before ack (>= TIMEOUT: never)
  typedef struct {
    logic       we;
    logic [2:0] adr;
    logic [7:0] dat;
    int         delay;
    logic [7:0] rdata;
    logic [3:0] sel;
    logic [7:0] rsp;
    logic       err;
    int         stb_cycles;
  } vec_t;

  vec_t vecs[7];

  // Stream stimulus: slave returns {5'b10100, adr} and never acks noack_adr
  logic       s_we  [8];
  logic [2:0] s_adr [8];
  logic [7:0] s_dat [8];
  logic [7:0] s_rsp [8];
  logic       s_err [8];
  int         stb_noack;

  task automatic run_cmd(input vec_t v, input int idx);
    int w;
    int cnt;
    @(negedge clk);
    cmd_valid_i = 1'b1;
    cmd_we_i    = v.we;
    cmd_adr_i   = v.adr;
    cmd_dat_i   = v.dat;
    wb_dat_i    = v.rdata;
    check($sformatf("v%0d_cmd_ready", idx), cmd_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid_i = 1'b0;
    w = 0;
    while (!wb_stb_o && w < 10) begin
      @(negedge clk);
      w++;
    end
    check($sformatf("v%0d_stb_latency", idx), w, 1);
    check($sformatf("v%0d_wb_we", idx), wb_we_o, v.we);
    check($sformatf("v%0d_wb_adr", idx), wb_adr_o, v.adr);
    check($sformatf("v%0d_wb_sel", idx), wb_sel_o, v.sel);
    if (v.we) check($sformatf("v%0d_wb_dat", idx), wb_dat_o, v.dat);
    cnt = 0;
    while (wb_stb_o && cnt < 40) begin
      cnt++;
      wb_ack_i = (cnt - 1 == v.delay);
      @(negedge clk);
      wb_ack_i = 1'b0;
    end
    check($sformatf("v%0d_stb_cycles", idx), cnt, v.stb_cycles);
    check($sformatf("v%0d_cyc_low", idx), wb_cyc_o, 0);
    check($sformatf("v%0d_rsp_valid", idx), rsp_valid_o, 1);
    check($sformatf("v%0d_rsp_dat", idx), rsp_dat_o, v.rsp);
    check($sformatf("v%0d_rsp_err", idx), rsp_err_o, v.err);
    rsp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_i = 1'b0;
    check($sformatf("v%0d_rsp_done", idx), rsp_valid_o, 0);
    check($sformatf("v%0d_busy_idle", idx), busy_o, 0);
  endtask

  task automatic run_stream(input string tag, input int n, input int release_c,
                            input int exp_accept, input int noack_adr);
    int  sent;
    int  got;
    logic acc;
    sent = 0;
    got  = 0;
    stb_noack = 0;
    for (int c = 0; c < 150 && got < n; c++) begin
      @(negedge clk);
      rsp_ready_i = (c >= release_c);
      if (release_c > 1 && c == release_c - 1) begin
        check({tag, "_accepted"}, sent, exp_accept);
        check({tag, "_ready_low"}, cmd_ready_o, 0);
        check({tag, "_rsp_held"}, rsp_valid_o, 1);
      end
      cmd_valid_i = (sent < n);
      if (sent < n) begin
        cmd_we_i  = s_we[sent];
        cmd_adr_i = s_adr[sent];
        cmd_dat_i = s_dat[sent];
      end
      wb_ack_i = wb_stb_o && (int'(wb_adr_o) != noack_adr);
      wb_dat_i = {5'b10100, wb_adr_o};
      if (wb_stb_o && int'(wb_adr_o) == noack_adr) stb_noack++;
      if (rsp_valid_o && rsp_ready_i) begin
        check($sformatf("%s_rsp%0d_dat", tag, got), rsp_dat_o, s_rsp[got]);
        check($sformatf("%s_rsp%0d_err", tag, got), rsp_err_o, s_err[got]);
        got++;
      end
      acc = cmd_valid_i && cmd_ready_o;
      @(posedge clk);
      if (acc) sent++;
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    wb_ack_i    = 1'b0;
    check({tag, "_responses"}, got, n);
    repeat (3) @(negedge clk);
    check({tag, "_no_extra_rsp"}, rsp_valid_o, 0);
    check({tag, "_busy_idle"}, busy_o, 0);
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int seen;

    vecs[0] = '{1'b1, 3'd3, 8'h83, 1,  8'hA5, 4'b1000, 8'h00, 1'b0, 2};
    vecs[1] = '{1'b0, 3'd5, 8'h00, 3,  8'h60, 4'b0010, 8'h60, 1'b0, 4};
    vecs[2] = '{1'b0, 3'd0, 8'h00, 0,  8'h3C, 4'b0001, 8'h3C, 1'b0, 1};
    vecs[3] = '{1'b0, 3'd2, 8'h00, 20, 8'h55, 4'b0100, 8'h00, 1'b1, 8};
    vecs[4] = '{1'b0, 3'd6, 8'h00, 7,  8'hC9, 4'b0100, 8'hC9, 1'b0, 8};
    vecs[5] = '{1'b1, 3'd1, 8'h7E, 9,  8'h42, 4'b0010, 8'h00, 1'b1, 8};
    vecs[6] = '{1'b1, 3'd4, 8'hFF, 0,  8'h11, 4'b0001, 8'h00, 1'b0, 1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cyc", wb_cyc_o, 0);
    check("rst_stb", wb_stb_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_adr", wb_adr_o, 0);
    check("rst_wb_dat", wb_dat_o, 0);
    check("rst_sel", wb_sel_o, 4'b0001);
    check("rst_rsp_valid", rsp_valid_o, 0);
    check("rst_rsp_dat", rsp_dat_o, 0);
    check("rst_rsp_err", rsp_err_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_cmd_ready", cmd_ready_o, 0);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready_o, 1);

    // Single-command table
    for (int i = 0; i < 7; i++) run_cmd(vecs[i], i);

    // Stray ack while idle
    wb_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_rsp_valid", rsp_valid_o, 0);
    check("stray_cyc", wb_cyc_o, 0);
    check("stray_busy", busy_o, 0);
    wb_ack_i = 1'b0;

    // Burst of 6 with responses stalled: 1 in flight + 4 queued accepted
    for (int i = 0; i < 6; i++) begin
      s_we[i]  = i[0];
      s_adr[i] = 3'(i + 1);
      s_dat[i] = 8'(8'h10 + i);
      s_rsp[i] = i[0] ? 8'h00 : {5'b10100, 3'(i + 1)};
      s_err[i] = 1'b0;
    end
    run_stream("burst", 6, 20, 5, -1);

    // Timeout followed by a queued command that completes normally
    s_we[0] = 1'b0; s_adr[0] = 3'd2; s_dat[0] = 8'h00; s_rsp[0] = 8'h00; s_err[0] = 1'b1;
    s_we[1] = 1'b0; s_adr[1] = 3'd7; s_dat[1] = 8'h00; s_rsp[1] = 8'hA7; s_err[1] = 1'b0;
    run_stream("tmo", 2, 0, 0, 2);
    check("tmo_stb_cycles", stb_noack, TIMEOUT);

    // Reset while a cycle is in flight with two queued commands
    wb_ack_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmd_valid_i = 1'b1;
      cmd_we_i    = 1'b0;
      cmd_adr_i   = 3'(i + 1);
      cmd_dat_i   = 8'h00;
      @(posedge clk);
    end
    @(negedge clk);
    cmd_valid_i = 1'b0;
    check("mid_stb_before", wb_stb_o, 1);
    #1 rst = 1'b0;
    #1;
    check("mid_cyc_drop", wb_cyc_o, 0);
    check("mid_stb_drop", wb_stb_o, 0);
    check("mid_busy_drop", busy_o, 0);
    check("mid_ready_in_rst", cmd_ready_o, 0);
    @(negedge clk);
    rst = 1'b1;
    rsp_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      wb_ack_i = wb_stb_o;
      if (rsp_valid_o || wb_stb_o) seen++;
    end
    wb_ack_i = 1'b0;
    check("mid_no_activity", seen, 0);
    check("mid_cmd_ready", cmd_ready_o, 1);
    check("mid_busy", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/peripheral_mpi_wb_master.md
Name: peripheral_mpi_wb_master

Overview:
Wishbone classic-cycle master that sits directly upstream of the 8-bit MPI/UART Wishbone slave (peripheral_wb_mpi) and drives its register port. It accepts register commands (read/write, 3-bit address, 8-bit data) on a valid/ready stream and buffers them in a small FIFO. It issues one Wishbone cycle per command, with a bounded ack timeout. It returns one response (read data plus error flag) per command on a valid/ready stream.

Parameters:
FIFO_DEPTH, 4, command FIFO entries; power of two, >=2
TIMEOUT, 255, max cycles stb is held waiting for ack; 0 = no timeout (wait forever)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
cmd_valid_i  input  1  command valid
cmd_ready_o  output  1  command accepted when valid&ready
cmd_we_i  input  1  1=write, 0=read
cmd_adr_i  input  3  register address
cmd_dat_i  input  8  write data
rsp_valid_o  output  1  response valid
rsp_ready_i  input  1  response consumed when valid&ready
rsp_dat_o  output  8  read data (0 for writes and errors)
rsp_err_o  output  1  1 = ack timeout
wb_adr_o  output  3  Wishbone address
wb_dat_o  output  8  Wishbone write data
wb_dat_i  input  8  Wishbone read data
wb_we_o  output  1  Wishbone write enable
wb_sel_o  output  4  byte select = 4'b0001 << wb_adr_o[1:0]
wb_stb_o  output  1  Wishbone strobe
wb_cyc_o  output  1  Wishbone cycle
wb_ack_i  input  1  Wishbone acknowledge
busy_o  output  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (rst low, async): FIFO emptied; FSM=IDLE; timer=0. wb_cyc_o, wb_stb_o, wb_we_o, rsp_valid_o, rsp_err_o, busy_o = 0. wb_adr_o, wb_dat_o, rsp_dat_o = 0. wb_sel_o = 4'b0001. cmd_ready_o forced 0 while rst low.
- Reset mid-transaction: cyc/stb drop immediately. The in-flight command and all queued commands are discarded; no response is produced for them.
- FIFO: cmd_ready_o = !full. Push on valid&ready. Push and pop in the same cycle are both honoured, including when full (pop frees a slot only from the next cycle; ready stays low that cycle). Pointers wrap modulo FIFO_DEPTH, with an extra bit for full/empty.
- FSM states IDLE, BUS, RESP.
- IDLE: if FIFO non-empty, pop the head and register adr/dat/we onto the wb_* outputs. Set cyc=stb=1, timer=0, go to BUS.
- BUS: cyc and stb held high; adr/dat/we/sel stable; timer increments each cycle.
  - wb_ack_i high at an edge: rsp_dat_o = we ? 0 : wb_dat_i, rsp_err_o = 0, cyc/stb = 0, go to RESP.
  - Else, if TIMEOUT != 0 and timer == TIMEOUT-1: rsp_dat_o = 0, rsp_err_o = 1, cyc/stb = 0, go to RESP. stb is therefore high for exactly TIMEOUT cycles.
  - ack and timeout on the same edge: ack wins.
- RESP: rsp_valid_o = 1; rsp_dat_o and rsp_err_o stable until rsp_ready_i. On valid&ready go to IDLE. Stalled rsp_ready_i back-pressures: no new bus cycle starts.
- wb_ack_i outside BUS is ignored.
- Latency: command accepted at edge N into an empty FIFO in IDLE gives stb high after edge N+1. Zero-wait ack at edge N+2 gives rsp_valid_o high after edge N+2. Minimum cycle-to-cycle spacing between back-to-back stb assertions is 3 clocks.
- Timer width: clog2(TIMEOUT+1); the timer saturates and never wraps.
- busy_o is registered-equivalent: high whenever FIFO is non-empty or state != IDLE.

Test Plan:
- Single write adr=3 dat=0x83, slave acks 1 cycle after stb -> wb_we_o=1, wb_sel_o=4'b1000, wb_dat_o=0x83, then rsp_valid_o=1, rsp_dat_o=0x00, rsp_err_o=0.
- Read adr=5, slave returns 0x60 with ack after 3 wait cycles -> stb high 4 cycles, rsp_dat_o=0x60, rsp_err_o=0, cyc low the cycle after ack.
- Burst of 6 commands with rsp_ready_i held 0 (FIFO_DEPTH=4) -> cmd_ready_o=0 after 5 accepted (1 in flight + 4 queued). Release rsp_ready_i -> 6 responses in command order, none lost or duplicated.
- TIMEOUT=8, slave never acks -> stb high exactly 8 cycles, then rsp_err_o=1, rsp_dat_o=0x00. Next queued command then proceeds normally.
- ack asserted on the same edge as timer==TIMEOUT-1 -> rsp_err_o=0, data captured. Stray ack while IDLE -> no response generated.
- rst pulled low while stb high with 2 queued commands -> cyc/stb/busy_o drop immediately. After release: no responses, cmd_ready_o=1.
